// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch sequencer.
// Owns the fetch PC and drives the instruction memory address from it. Returned
// words are buffered in a small FIFO and handed to decode with valid/ready.
// A redirect flushes the FIFO and reloads the PC. Halt stops new fetches.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  input  logic        if_ready,
  output logic [31:0] fetch_pc,
  output logic        busy,
  output logic [31:0] retired_cnt
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  typedef enum logic {FETCH, HALTED} state_t;

  state_t        state;
  state_t        state_next;
  logic [31:0]   mem_pc    [DEPTH];
  logic [31:0]   mem_instr [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [31:0]   last_pc;
  logic [31:0]   last_instr;
  logic          push;
  logic          pop;

  assign imem_addr = fetch_pc;
  assign if_valid  = (count != '0);
  assign if_pc     = if_valid ? mem_pc[rd_ptr]    : last_pc;
  assign if_instr  = if_valid ? mem_instr[rd_ptr] : last_instr;
  assign busy      = (state == FETCH) || (count != '0);
  assign pop       = if_valid && if_ready;

  // Next state and the push decision; a halting edge never fetches.
  always_comb begin
    state_next = state;
    push       = 1'b0;
    case (state)
      FETCH: begin
        if (halt) begin
          state_next = HALTED;
        end else if (!redirect_valid && ((count != FULL) || pop)) begin
          push = 1'b1;
        end
      end
      HALTED: begin
        if (!halt) begin
          state_next = FETCH;
        end
      end
      default: state_next = FETCH;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FETCH;
    end else begin
      state <= state_next;
    end
  end

  // Fetch PC: redirect reloads an aligned target, a push advances one word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc <= RESET_PC;
    end else if (redirect_valid) begin
      fetch_pc <= redirect_pc & 32'hFFFF_FFFC;
    end else if (push) begin
      fetch_pc <= fetch_pc + 32'd4;
    end
  end

  // FIFO storage; the tail slot is written on every push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_pc[i]    <= '0;
        mem_instr[i] <= '0;
      end
    end else if (push) begin
      mem_pc[wr_ptr]    <= fetch_pc;
      mem_instr[wr_ptr] <= imem_rdata;
    end
  end

  // FIFO pointers and occupancy; a redirect empties the queue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (redirect_valid) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
    end
  end

  // Remember what decode last saw so the outputs hold while the FIFO is empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_pc    <= '0;
      last_instr <= '0;
    end else begin
      last_pc    <= if_pc;
      last_instr <= if_instr;
    end
  end

  // Retired-instruction counter, one per accepted handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retired_cnt <= '0;
    end else if (pop) begin
      retired_cnt <= retired_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: self-checking bench for fetch_ctrl with a small program memory.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        halt = 1'b0;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        if_ready = 1'b0;
  logic [31:0] fetch_pc;
  logic        busy;
  logic [31:0] retired_cnt;

  int n_checks = 0;
  int n_fails  = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } sb_t;

  sb_t sb_q[$];

  typedef struct {
    logic        redirect;
    logic [31:0] rpc;
    logic        halt;
    logic        ready;
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic [31:0] exp_instr;
    logic [31:0] exp_fetch;
    logic        exp_busy;
    logic [31:0] exp_ret;
  } vec_t;

  vec_t vecs[16];

  fetch_ctrl #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .imem_addr(imem_addr),
    .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .halt(halt),
    .if_valid(if_valid),
    .if_instr(if_instr),
    .if_pc(if_pc),
    .if_ready(if_ready),
    .fetch_pc(fetch_pc),
    .busy(busy),
    .retired_cnt(retired_cnt)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Behavioural zero-latency instruction memory.
  always_comb begin
    case (imem_addr)
      32'h0000_0000: imem_rdata = 32'h0000_0820;
      32'h0000_0004: imem_rdata = 32'h2001_000A;
      32'h0000_0008: imem_rdata = 32'h2002_0014;
      32'h0000_000C: imem_rdata = 32'h0022_1820;
      default:       imem_rdata = 32'h0000_0000;
    endcase
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input logic rd, input logic [31:0] rpc, input logic h, input logic rdy);
    redirect_valid = rd;
    redirect_pc    = rpc;
    halt           = h;
    if_ready       = rdy;
  endtask

  initial begin
    sb_t got;
    sb_t exp;
    // Cycle-by-cycle vectors from a fresh reset: back-pressure, redirect, halt, wrap.
    vecs[0]  = '{1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 32'h0,         32'h0000_0820, 32'h4,         1'b1, 32'd0};
    vecs[1]  = '{1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 32'h0,         32'h0000_0820, 32'h8,         1'b1, 32'd0};
    vecs[2]  = '{1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 32'h0,         32'h0000_0820, 32'h8,         1'b1, 32'd0};
    vecs[3]  = '{1'b0, 32'h0,         1'b0, 1'b1, 1'b1, 32'h4,         32'h2001_000A, 32'hC,         1'b1, 32'd1};
    vecs[4]  = '{1'b0, 32'h0,         1'b0, 1'b1, 1'b1, 32'h8,         32'h2002_0014, 32'h10,        1'b1, 32'd2};
    vecs[5]  = '{1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 32'h8,         32'h2002_0014, 32'h10,        1'b1, 32'd2};
    vecs[6]  = '{1'b1, 32'h0000_000E, 1'b0, 1'b0, 1'b0, 32'h8,         32'h2002_0014, 32'hC,         1'b1, 32'd2};
    vecs[7]  = '{1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 32'hC,         32'h0022_1820, 32'h10,        1'b1, 32'd2};
    vecs[8]  = '{1'b0, 32'h0,         1'b1, 1'b1, 1'b0, 32'hC,         32'h0022_1820, 32'h10,        1'b0, 32'd3};
    vecs[9]  = '{1'b0, 32'h0,         1'b1, 1'b1, 1'b0, 32'hC,         32'h0022_1820, 32'h10,        1'b0, 32'd3};
    vecs[10] = '{1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 32'hC,         32'h0022_1820, 32'h10,        1'b1, 32'd3};
    vecs[11] = '{1'b0, 32'h0,         1'b0, 1'b1, 1'b1, 32'h10,        32'h0,         32'h14,        1'b1, 32'd3};
    vecs[12] = '{1'b1, 32'hFFFF_FFFC, 1'b0, 1'b1, 1'b0, 32'h10,        32'h0,         32'hFFFF_FFFC, 1'b1, 32'd4};
    vecs[13] = '{1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 32'h0,         32'h0,         1'b1, 32'd4};
    vecs[14] = '{1'b0, 32'h0,         1'b0, 1'b1, 1'b1, 32'h0,         32'h0000_0820, 32'h4,         1'b1, 32'd5};
    vecs[15] = '{1'b0, 32'h0,         1'b0, 1'b1, 1'b1, 32'h4,         32'h2001_000A, 32'h8,         1'b1, 32'd6};

    // Reset values.
    #1;
    check_output("rst_if_valid", {31'b0, if_valid}, 32'd0);
    check_output("rst_if_pc", if_pc, 32'h0);
    check_output("rst_if_instr", if_instr, 32'h0);
    check_output("rst_fetch_pc", fetch_pc, 32'h0);
    check_output("rst_imem_addr", imem_addr, 32'h0);
    check_output("rst_retired", retired_cnt, 32'd0);
    check_output("rst_busy", {31'b0, busy}, 32'd1);

    // Streaming run with decode always ready, checked through the scoreboard.
    sb_q.push_back('{pc: 32'h0, instr: 32'h0000_0820});
    sb_q.push_back('{pc: 32'h4, instr: 32'h2001_000A});
    sb_q.push_back('{pc: 32'h8, instr: 32'h2002_0014});
    sb_q.push_back('{pc: 32'hC, instr: 32'h0022_1820});
    @(negedge clk);
    rst_n = 1'b1;
    apply_stimulus(1'b0, 32'h0, 1'b0, 1'b1);
    for (int cyc = 0; cyc < 20 && sb_q.size() > 0; cyc++) begin
      @(negedge clk);
      #1;
      if (if_valid && if_ready) begin
        exp = sb_q.pop_front();
        got = '{pc: if_pc, instr: if_instr};
        check_output("sb_pc", got.pc, exp.pc);
        check_output("sb_instr", got.instr, exp.instr);
      end
    end
    check_output("sb_timeout_left", sb_q.size(), 32'd0);
    @(posedge clk);
    #1;
    check_output("flow_retired", retired_cnt, 32'd4);

    // Asynchronous reset between edges clears everything immediately.
    #3;
    rst_n = 1'b0;
    #1;
    check_output("midrst_if_valid", {31'b0, if_valid}, 32'd0);
    check_output("midrst_fetch_pc", fetch_pc, 32'h0);
    check_output("midrst_retired", retired_cnt, 32'd0);
    check_output("midrst_if_pc", if_pc, 32'h0);

    // Table-driven vectors from a fresh release of reset.
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      rst_n = 1'b1;
      apply_stimulus(vecs[i].redirect, vecs[i].rpc, vecs[i].halt, vecs[i].ready);
      @(posedge clk);
      #1;
      check_output($sformatf("v%0d_if_valid", i), {31'b0, if_valid}, {31'b0, vecs[i].exp_valid});
      check_output($sformatf("v%0d_if_pc", i), if_pc, vecs[i].exp_pc);
      check_output($sformatf("v%0d_if_instr", i), if_instr, vecs[i].exp_instr);
      check_output($sformatf("v%0d_fetch_pc", i), fetch_pc, vecs[i].exp_fetch);
      check_output($sformatf("v%0d_imem_addr", i), imem_addr, vecs[i].exp_fetch);
      check_output($sformatf("v%0d_busy", i), {31'b0, busy}, {31'b0, vecs[i].exp_busy});
      check_output($sformatf("v%0d_retired", i), retired_cnt, vecs[i].exp_ret);
    end

    @(negedge clk);
    apply_stimulus(1'b0, 32'h0, 1'b0, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
